// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, RD, WR} state_e;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_WORD = 3'b010;

    // Fixed AXI attributes for the single-beat, non-bursting master
    localparam logic [1:0] AXI_BURST = 2'b00;
    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [3:0] AXI_CACHE = 4'b0011;
    localparam logic [3:0] AXI_ID    = 4'd0;
endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane strobe/data generation and read byte extraction
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [2:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);
    always_comb begin
        st_strb  = 4'hf;
        st_wdata = st_data;
        ld_data  = ld_rdata;
        // Byte stores drive every lane so the slave picks the right one via wstrb
        if (st_size == SZ_BYTE) begin
            st_strb  = 4'b0001 << st_lane;
            st_wdata = {4{st_data[7:0]}};
        end
        if (ld_size == SZ_BYTE) begin
            ld_data = {24'h0, ld_rdata[{ld_lane, 3'b000} +: 8]};
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one AXI4 master between fetch and load/store ports
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 29
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [2:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       resp_data,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    output logic              wlast,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);
    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              port_q, port_d;
    logic [2:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;

    logic        m0_elig, m1_elig;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata, ld_data;

    mem_lane_align u_align (
        .st_size  (m1_size),
        .st_lane  (m1_addr[1:0]),
        .st_data  (m1_wdata),
        .st_strb  (st_strb),
        .st_wdata (st_wdata),
        .ld_size  (size_q),
        .ld_lane  (addr_q[1:0]),
        .ld_rdata (rdata),
        .ld_data  (ld_data)
    );

    // A port acked this cycle still has req high; it must not be granted again
    assign m0_elig = m0_req & ~m0_ack_q;
    assign m1_elig = m1_req & ~m1_ack_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        resp_data_d  = resp_data_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_elig && (!m1_elig || last_grant_q)) begin
                    state_d      = RD;
                    last_grant_d = 1'b0;
                    port_d       = 1'b0;
                    size_d       = SZ_WORD;
                    addr_d       = m0_addr;
                    arvalid_d    = 1'b1;
                    rready_d     = 1'b1;
                end else if (m1_elig) begin
                    last_grant_d = 1'b1;
                    port_d       = 1'b1;
                    size_d       = m1_size;
                    addr_d       = m1_addr;
                    if (m1_we) begin
                        state_d   = WR;
                        wdata_d   = st_wdata;
                        wstrb_d   = st_strb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end
            RD: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                end
                if (rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    resp_data_d = ld_data;
                    m0_ack_d    = ~port_q;
                    m1_ack_d    = port_q;
                    state_d     = IDLE;
                end
            end
            WR: begin
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // The response only counts once both address and data have been accepted
                if (bvalid && bready_q && aw_done_q && w_done_q) begin
                    bready_d = 1'b0;
                    m1_ack_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            size_q       <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            resp_data_q  <= 32'h0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            resp_data_q  <= resp_data_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign resp_data = resp_data_q;
    assign araddr    = addr_q;
    assign arsize    = size_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awaddr    = addr_q;
    assign awsize    = size_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign wlast     = wvalid_q;
    assign bready    = bready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int ADDR_W = 29;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_ack, m1_req, m1_we, m1_ack;
    logic [ADDR_W-1:0] m0_addr, m1_addr, araddr, awaddr;
    logic [2:0]        m1_size, arsize, awsize;
    logic [31:0]       m1_wdata, resp_data, rdata, wdata;
    logic              arvalid, arready, rvalid, rready, awvalid, awready;
    logic [3:0]        wstrb;
    logic              wvalid, wlast, wready, bvalid, bready;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .resp_data(resp_data),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        int          port;
        bit          we;
        logic [2:0]  size;
        logic [28:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   ack_ports[$];
    int   checks = 0;
    int   failures = 0;

    int   ar_dly = 0, aw_dly = 0, w_dly = 0;
    bit   b_early = 0;
    int   ar_wait, aw_wait, w_wait, ar_cnt;
    bit   ar_fire, aw_fire, w_fire, r_fire, r_pend, aw_seen, w_seen, prev_ack;
    logic [31:0] r_word;
    logic [28:0] cap_araddr;
    logic [2:0]  cap_arsize;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_wlast;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (event not expected or never arrived)", name);
    endtask

    // Slave memory contents: two pinned words, everything else a fixed address pattern
    function automatic logic [31:0] mem_rd(input logic [28:0] a);
        logic [28:0] w;
        w = {a[28:2], 2'b00};
        if (w == 29'h100) return 32'h12345678;
        if (w == 29'h200) return 32'hAABBCCDD;
        return {3'b000, w} ^ 32'hC3C30000;
    endfunction

    function automatic logic [31:0] exp_resp(input txn_t t);
        logic [31:0] word;
        word = mem_rd(t.addr);
        if (t.size == 3'b000) return (word >> (8 * int'(t.addr[1:0]))) & 32'h0000_00ff;
        return word;
    endfunction

    function automatic logic [31:0] exp_wdata(input txn_t t);
        if (t.size == 3'b000) return 32'h01010101 * {24'h0, t.data[7:0]};
        return t.data;
    endfunction

    function automatic logic [3:0] exp_wstrb(input txn_t t);
        if (t.size == 3'b000) return 4'(1 << int'(t.addr[1:0]));
        return 4'hf;
    endfunction

    task automatic push_exp(input int port, input bit we, input logic [2:0] size,
                            input logic [28:0] addr, input logic [31:0] data);
        txn_t t;
        t.port = port; t.we = we; t.size = size; t.addr = addr; t.data = data;
        exp_q.push_back(t);
    endtask

    // Slave model plus scoreboard: evaluates at every falling edge
    initial begin
        txn_t e;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rdata = 0;
                ar_fire = 0; aw_fire = 0; w_fire = 0; r_fire = 0; r_pend = 0;
                aw_seen = 0; w_seen = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
                ar_cnt = 0; prev_ack = 0;
                continue;
            end
            if (ar_fire) begin r_pend = 1; r_word = mem_rd(cap_araddr); ar_cnt++; end
            if (r_fire) r_pend = 0;
            if (aw_fire) aw_seen = 1;
            if (w_fire) w_seen = 1;

            if (m0_ack || m1_ack) begin
                chk("single_ack", 32'(m0_ack && m1_ack), 32'd0);
                chk("ack_one_cycle", 32'(prev_ack), 32'd0);
                if (exp_q.size() == 0) fail_now("unexpected_ack");
                else begin
                    e = exp_q.pop_front();
                    chk("ack_port", 32'(m1_ack), 32'(e.port));
                    ack_ports.push_back(m1_ack ? 1 : 0);
                    if (!e.we) begin
                        chk("resp_data", resp_data, exp_resp(e));
                        chk("ar_per_txn", 32'(ar_cnt), 32'd1);
                    end else begin
                        chk("aw_w_before_ack", 32'({aw_seen, w_seen}), 32'd3);
                    end
                end
                ar_cnt = 0; aw_seen = 0; w_seen = 0;
            end
            prev_ack = m0_ack || m1_ack;
            chk("wlast_eq_wvalid", 32'(wlast), 32'(wvalid));

            arready = arvalid && (ar_wait >= ar_dly);
            if (arvalid && !arready) ar_wait++;
            awready = awvalid && (aw_wait >= aw_dly);
            if (awvalid && !awready) aw_wait++;
            wready = wvalid && (w_wait >= w_dly);
            if (wvalid && !wready) w_wait++;
            rvalid = r_pend;
            rdata  = r_pend ? r_word : 32'h0;
            bvalid = b_early ? w_seen : (aw_seen && w_seen);

            ar_fire = arvalid && arready;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            r_fire  = rvalid && rready;

            if (ar_fire) begin
                ar_wait = 0; cap_araddr = araddr; cap_arsize = arsize;
                if (exp_q.size() == 0 || exp_q[0].we) fail_now("unexpected_ar");
                else begin
                    chk("araddr", 32'(araddr), 32'(exp_q[0].addr));
                    chk("arsize", 32'(arsize), 32'(exp_q[0].size));
                end
            end
            if (aw_fire) begin
                aw_wait = 0;
                if (exp_q.size() == 0 || !exp_q[0].we) fail_now("unexpected_aw");
                else begin
                    chk("awaddr", 32'(awaddr), 32'(exp_q[0].addr));
                    chk("awsize", 32'(awsize), 32'(exp_q[0].size));
                end
            end
            if (w_fire) begin
                w_wait = 0; cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast;
                if (exp_q.size() == 0 || !exp_q[0].we) fail_now("unexpected_w");
                else begin
                    chk("wdata", wdata, exp_wdata(exp_q[0]));
                    chk("wstrb", 32'(wstrb), 32'(exp_wstrb(exp_q[0])));
                end
            end
        end
    end

    task automatic do_txn(input int port, input bit we, input logic [2:0] size,
                          input logic [28:0] addr, input logic [31:0] data,
                          input bit keep, output int lat);
        int cyc;
        bit got;
        cyc = 0; got = 0;
        if (port == 0) begin
            m0_addr = addr; m0_req = 1;
        end else begin
            m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = data; m1_req = 1;
        end
        while (!got && cyc < 60) begin
            @(negedge clk);
            if ((port == 0 && m0_ack) || (port == 1 && m1_ack)) got = 1;
            else cyc++;
        end
        if (!got) fail_now(port == 0 ? "m0_ack_timeout" : "m1_ack_timeout");
        lat = cyc;
        @(posedge clk); #1;
        if (!keep) begin
            if (port == 0) m0_req = 0;
            else m1_req = 0;
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready",  32'(rready),  32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid",  32'(wvalid),  32'd0);
        chk("rst_wlast",   32'(wlast),   32'd0);
        chk("rst_bready",  32'(bready),  32'd0);
        chk("rst_acks",    32'({m0_ack, m1_ack}), 32'd0);
        chk("rst_wstrb",   32'(wstrb),   32'd0);
        chk("rst_wdata",   wdata,        32'd0);
        chk("rst_resp",    resp_data,    32'd0);
        chk("rst_araddr",  32'(araddr),  32'd0);
        chk("rst_awaddr",  32'(awaddr),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, lat, acks_before;
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};
        rst = 1; m0_req = 0; m0_addr = '0; m1_req = 0; m1_we = 0;
        m1_size = 3'b000; m1_addr = '0; m1_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero();
        rst = 0;
        @(posedge clk); #1;

        // Both ports requesting back to back from reset: port 0 wins the first tie
        push_exp(0, 0, 3'b010, 29'h10, 32'h0);
        push_exp(1, 0, 3'b000, 29'h21, 32'h0);
        push_exp(0, 0, 3'b010, 29'h14, 32'h0);
        push_exp(1, 1, 3'b010, 29'h30, 32'h0BADF00D);
        fork
            begin
                do_txn(0, 0, 3'b010, 29'h10, 32'h0, 1, l0);
                do_txn(0, 0, 3'b010, 29'h14, 32'h0, 0, l0);
            end
            begin
                do_txn(1, 0, 3'b000, 29'h21, 32'h0, 1, l1);
                do_txn(1, 1, 3'b010, 29'h30, 32'h0BADF00D, 0, l1);
            end
        join
        chk("grant_count", 32'(ack_ports.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_ports.size(); i++)
            chk($sformatf("grant_order_%0d", i), 32'(ack_ports[i]), 32'(exp_order[i]));

        // Fetch word read
        push_exp(0, 0, 3'b010, 29'h100, 32'h0);
        do_txn(0, 0, 3'b010, 29'h100, 32'h0, 0, lat);
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_resp", resp_data, 32'h12345678);
        chk("t1_araddr", 32'(cap_araddr), 32'h100);
        chk("t1_arsize", 32'(cap_arsize), 32'd2);
        repeat (5) @(posedge clk);
        #1;

        // Exec byte load from the top lane
        push_exp(1, 0, 3'b000, 29'h203, 32'h0);
        do_txn(1, 0, 3'b000, 29'h203, 32'h0, 0, lat);
        chk("t2_latency", 32'(lat), 32'd3);
        chk("t2_resp", resp_data, 32'h000000AA);
        chk("t2_arsize", 32'(cap_arsize), 32'd0);

        // Byte store, AW held off 3 cycles, slave raises bvalid early
        aw_dly = 3; b_early = 1;
        push_exp(1, 1, 3'b000, 29'h302, 32'hFFFFFF5A);
        do_txn(1, 1, 3'b000, 29'h302, 32'hFFFFFF5A, 0, lat);
        chk("t3_latency", 32'(lat), 32'd6);
        chk("t3_wstrb", 32'(cap_wstrb), 32'h4);
        chk("t3_wdata", cap_wdata, 32'h5A5A5A5A);
        aw_dly = 0; b_early = 0;

        // Word store
        push_exp(1, 1, 3'b010, 29'h40, 32'hDEADBEEF);
        do_txn(1, 1, 3'b010, 29'h40, 32'hDEADBEEF, 0, lat);
        chk("t5_latency", 32'(lat), 32'd3);
        chk("t5_wstrb", 32'(cap_wstrb), 32'hf);
        chk("t5_wdata", cap_wdata, 32'hDEADBEEF);
        chk("t5_wlast", 32'(cap_wlast), 32'd1);

        // Reset while a read is waiting on arready
        ar_dly = 5;
        push_exp(0, 0, 3'b010, 29'h180, 32'h0);
        m0_addr = 29'h180; m0_req = 1;
        repeat (2) @(negedge clk);
        chk("t6_rd_started", 32'(arvalid), 32'd1);
        #2 rst = 1;
        #1;
        chk_all_zero();
        exp_q.delete();
        m0_req = 0;
        acks_before = ack_ports.size();
        @(posedge clk); #1;
        rst = 0;
        ar_dly = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_ack", 32'(ack_ports.size()), 32'(acks_before));

        // Back in IDLE: a fresh fetch completes at minimum latency
        push_exp(0, 0, 3'b010, 29'h100, 32'h0);
        do_txn(0, 0, 3'b010, 29'h100, 32'h0, 0, lat);
        chk("t6_post_latency", 32'(lat), 32'd3);
        chk("t6_post_resp", resp_data, 32'h12345678);
        repeat (3) @(posedge clk);
        #1;
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
